cc_driver: RTL and testbench
============================

Name: cc_driver

Overview:
- Initiator for the cross-correlator core, i.e. the side that drives its start/m0/m1 interface and consumes its done/index outputs.
- Buffers one full frame of N sample pairs from an upstream valid/ready stream.
- Issues a one-cycle start and streams the frame gap-free, one pair per cycle, as the correlator requires.
- Waits for done, then presents the winning lag on a valid/ready result port, with a timeout guard.

Parameters:
- N, 1024, samples per channel per frame; must equal the correlator's frame length.
- DW, 16, sample width.
- TIMEOUT, 65536, maximum cycles from end of streaming to cc_done before aborting (correlator worst case is about 62.5k).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream sample pair valid.
- s_ready  out  1  block accepts a pair this cycle.
- s_m0  in  DW  channel-0 sample.
- s_m1  in  DW  channel-1 sample.
- cc_start  out  1  start pulse to correlator.
- cc_m0  out  DW  channel-0 sample to correlator.
- cc_m1  out  DW  channel-1 sample to correlator.
- cc_done  in  1  correlator done level.
- cc_index  in  16  correlator best lag, two's complement.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_index  out  16  captured lag.
- res_timeout  out  1  qualifies res_valid; 1 means no done was seen and res_index = 0.
- busy  out  1  high in every state except FILL.

Behaviour:
- Reset (asynchronous, rst_n low): state FILL, fill pointer 0, timeout counter 0, all outputs 0 except s_ready, which is 1 once rst_n is high. The correlator is not reset by this block; a mid-operation reset may leave it mid-run.
- Storage: two N x DW buffers with a registered read (1-cycle latency).
- FILL:
  - s_ready = 1.
  - Pair written at fill pointer on s_valid & s_ready; pointer increments.
  - Gaps in s_valid are allowed.
  - When the write to address N-1 occurs, go to START. That same cycle s_ready drops to 0 for the next cycle.
- START, 1 cycle:
  - cc_start = 1; read address 0 issued; go to STREAM.
- STREAM, exactly N cycles:
  - In cycle j (j = 0..N-1, the first being the cycle after cc_start), cc_m0/cc_m1 = buffer[j].
  - cc_start = 0 throughout.
  - After cycle N-1, go to WAIT with timeout counter cleared.
  - Contract: the correlator samples m0/m1 on N consecutive cycles starting the cycle after it sees start, so there are no gaps or stalls.
- Outside STREAM: cc_m0 = cc_m1 = 0.
- WAIT:
  - Counter increments each cycle.
  - On the first cycle cc_done = 1: res_index <= cc_index, res_timeout <= 0, go to RESULT.
  - If the counter reaches TIMEOUT-1 without cc_done: res_index <= 0, res_timeout <= 1, go to RESULT.
  - If cc_done and the timeout coincide, done wins.
- RESULT:
  - res_valid = 1; res_index and res_timeout are held stable until handshake.
  - On res_valid & res_ready: res_valid <= 0, fill pointer <= 0, go to FILL.
  - res_ready high on the first RESULT cycle gives a 1-cycle result.
- Restart: correlator accepts start from Idle or Done with identical timing, so back-to-back frames need no extra handling. Its stale cc_done from the previous run falls before WAIT is entered (N+1 cycles later), so it is never misread.
- Frame period, best case: N fill + 1 + N stream + correlator latency + 1 result cycle.
- Width rules: fill pointer and read address are clog2(N) bits. Timeout counter is clog2(TIMEOUT)+1 bits and saturates. cc_index is passed through unmodified, sign preserved.

Test Plan:
- Ramp fill: s_m0 = k, s_m1 = 1023-k, s_valid held high, with a correlator model. Required: exactly one cc_start cycle, cc_m0 = 0..1023 on the following 1024 cycles, s_ready low from START until the result handshake.
- Upstream gaps: s_valid toggled on a random 50% pattern. Required: stored order is unchanged and the streamed sequence is identical to the gap-free case.
- Result backpressure: model returns cc_index = 16'hFFFB (-5), res_ready low for 7 cycles. Required: res_valid, res_index = FFFB and res_timeout = 0 all held stable for 8 cycles; FILL resumes after the handshake.
- Timeout: cc_done tied 0, TIMEOUT = 100. Required: res_valid with res_timeout = 1 and res_index = 0 exactly 100 cycles after the last STREAM cycle.
- Reset mid-STREAM: rst_n low at stream cycle 300. Required: all outputs 0 immediately (asynchronous); after release s_ready = 1, fill pointer = 0, no cc_start until 1024 new pairs are accepted.
- Back-to-back: two frames with the real cc_1 core and a lag of +7 embedded. Required: both results give index 7, and the second cc_start is issued while the core is in Done.

Source files
------------

// File: rtl/cc_driver.sv
// cc_driver: buffers one frame of sample pairs, streams it gap-free to the cross-correlator,
// then returns the winning lag (or a timeout flag) on a valid/ready result port.
module cc_driver #(
    parameter int N       = 1024,
    parameter int DW      = 16,
    parameter int TIMEOUT = 65536
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_m0,
    input  logic [DW-1:0] s_m1,
    output logic          cc_start,
    output logic [DW-1:0] cc_m0,
    output logic [DW-1:0] cc_m1,
    input  logic          cc_done,
    input  logic [15:0]   cc_index,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [15:0]   res_index,
    output logic          res_timeout,
    output logic          busy
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {FILL, START, STREAM, WAIT, RESULT} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mem0 [N];
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] rd0, rd1;
    logic          last;
    logic [AW-1:0] nxt;

    assign last      = ptr == AW'(N - 1);
    assign nxt       = last ? '0 : ptr + AW'(1);
    assign s_ready   = rst_n && state == FILL;
    assign busy      = state != FILL;
    assign cc_start  = state == START;
    assign res_valid = state == RESULT;
    assign cc_m0     = state == STREAM ? rd0 : '0;
    assign cc_m1     = state == STREAM ? rd1 : '0;

    // ptr is the write address while filling and the read-ahead address while streaming
    always_ff @(posedge clk) begin
        if (s_valid && s_ready) begin
            mem0[ptr] <= s_m0;
            mem1[ptr] <= s_m1;
        end
        rd0 <= mem0[ptr];
        rd1 <= mem1[ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            ptr         <= '0;
            cnt         <= '0;
            res_index   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                FILL: if (s_valid) begin
                    ptr <= nxt;
                    if (last) state <= START;
                end
                START: begin
                    ptr   <= nxt;
                    state <= STREAM;
                end
                // ptr wraps to 0 exactly when the final sample is on the output
                STREAM: if (ptr == '0) begin
                    state <= WAIT;
                    cnt   <= '0;
                end else ptr <= nxt;
                WAIT: begin
                    cnt <= &cnt ? cnt : cnt + CW'(1);
                    if (cc_done) begin
                        res_index   <= cc_index;
                        res_timeout <= 1'b0;
                        state       <= RESULT;
                    end else if (cnt >= CW'(TIMEOUT - 2)) begin
                        res_index   <= '0;
                        res_timeout <= 1'b1;
                        state       <= RESULT;
                    end
                end
                RESULT: if (res_ready) begin
                    state <= FILL;
                    ptr   <= '0;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_cc_driver.sv
// tb_cc_driver: randomized frames against a behavioural correlator and a scoreboard of accepted pairs.
module tb_cc_driver;
    localparam int N  = 1024;
    localparam int DW = 16;
    localparam int TO = 100;

    logic          clk = 0, rst_n = 1;
    logic          s_valid = 0, s_ready;
    logic [DW-1:0] s_m0 = 0, s_m1 = 0;
    logic          cc_start;
    logic [DW-1:0] cc_m0, cc_m1;
    logic          cc_done = 0;
    logic [15:0]   cc_index = 0;
    logic          res_valid, res_ready = 0, res_timeout, busy;
    logic [15:0]   res_index;

    cc_driver #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_m0(s_m0), .s_m1(s_m1),
        .cc_start(cc_start), .cc_m0(cc_m0), .cc_m1(cc_m1), .cc_done(cc_done), .cc_index(cc_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // correlator model: 0 idle, 1 collecting, 2 computing, 3 done
    int            mmode = 0, mcnt = 0, lcnt = 0, lat = 20, no_done = 0;
    logic [15:0]   midx = 0;
    logic [DW-1:0] got0 [N], got1 [N], e0 [N], e1 [N];
    int            starts = 0, start_cyc = 0, last_stream_cyc = 0, leak = 0, rviol = 0, start_in_done = 0;

    always @(negedge clk) begin
        if (mmode != 1 && (cc_m0 != 0 || cc_m1 != 0)) leak++;
        if (busy && s_ready) rviol++;
        if (cc_start) begin
            starts++;
            start_cyc = cyc;
            start_in_done = (mmode == 3) ? 1 : 0;
            mmode = 1;
            mcnt = 0;
            cc_done = 0;
        end else if (mmode == 1) begin
            got0[mcnt] = cc_m0;
            got1[mcnt] = cc_m1;
            mcnt++;
            if (mcnt == N) begin
                mmode = 2;
                lcnt = 0;
                last_stream_cyc = cyc;
            end
        end else if (mmode == 2) begin
            lcnt++;
            if (lcnt == lat && no_done == 0) begin
                cc_done = 1;
                cc_index = midx;
                mmode = 3;
            end
        end
    end

    task automatic fill(input bit ramp, input bit gaps, output int acc);
        int k = 0, guard = 0;
        acc = 0;
        while (k < N && guard < 20 * N) begin
            @(negedge clk);
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_m0 = ramp ? DW'(k) : DW'($urandom);
            s_m1 = ramp ? DW'(N - 1 - k) : DW'($urandom);
            if (s_valid && s_ready) begin
                e0[k] = s_m0;
                e1[k] = s_m1;
                acc = cyc;
                k++;
            end
            guard++;
        end
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("fill_count", k, N);
    endtask

    task automatic wait_result(output int rc);
        int g = 0;
        while (!res_valid && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("res_valid_seen", res_valid, 1);
        rc = cyc;
    endtask

    task automatic check_frame(input string tag, input int acc, input int s0);
        int bad = 0;
        for (int i = 0; i < N; i++) if (got0[i] !== e0[i] || got1[i] !== e1[i]) bad++;
        chk({tag, "_stream"}, bad, 0);
        chk({tag, "_starts"}, starts - s0, 1);
        chk({tag, "_start_cyc"}, start_cyc - acc, 1);
    endtask

    task automatic handshake();
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("hs_valid_low", res_valid, 0);
        chk("hs_fill", s_ready, 1);
    endtask

    initial begin
        int acc, rc, s0, bad, g;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready_low", s_ready, 0);
        rst_n = 1;
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {cc_start, res_valid, res_timeout, res_index, cc_m0}, 0);

        // ramp, gap-free, immediate result acceptance
        lat = 20; midx = 16'h0007; s0 = starts;
        fill(1, 0, acc);
        wait_result(rc);
        check_frame("f1", acc, s0);
        chk("f1_index", res_index, 16'h0007);
        chk("f1_timeout", res_timeout, 0);
        chk("f1_latency", rc - last_stream_cyc, lat + 1);
        handshake();

        // ramp with upstream gaps, backpressured negative lag, started while core is done
        lat = int'($urandom_range(1, 90)); midx = 16'hFFFB; s0 = starts;
        fill(1, 1, acc);
        chk("f2_start_in_done", start_in_done, 1);
        wait_result(rc);
        check_frame("f2", acc, s0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (!res_valid || res_index !== 16'hFFFB || res_timeout !== 1'b0) bad++;
            if (i == 7) res_ready = 1;
            @(negedge clk);
        end
        res_ready = 0;
        chk("f2_hold", bad, 0);
        chk("f2_valid_low", res_valid, 0);
        chk("f2_fill", s_ready, 1);

        // no done: timeout
        no_done = 1; s0 = starts;
        fill(0, 1, acc);
        wait_result(rc);
        check_frame("f3", acc, s0);
        chk("f3_timeout_cycles", rc - last_stream_cyc, TO);
        chk("f3_timeout", res_timeout, 1);
        chk("f3_index", res_index, 0);
        handshake();
        no_done = 0;

        // done on the same cycle the timeout fires: done wins
        lat = TO - 1; midx = 16'h1234; s0 = starts;
        fill(0, 0, acc);
        wait_result(rc);
        check_frame("f4", acc, s0);
        chk("f4_tie_cycles", rc - last_stream_cyc, TO);
        chk("f4_timeout", res_timeout, 0);
        chk("f4_index", res_index, 16'h1234);
        handshake();

        // asynchronous reset in the middle of streaming
        lat = 30; midx = 16'h8000;
        fill(0, 0, acc);
        g = 0;
        while (mcnt < 300 && g < 5000) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("f5_reached_300", mcnt, 300);
        #2 rst_n = 0;
        #1;
        chk("f5_rst_outs", {s_ready, busy, cc_start, res_valid, res_timeout, res_index, cc_m0, cc_m1}, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("f5_rel_s_ready", s_ready, 1);
        chk("f5_rel_busy", busy, 0);
        s0 = starts;
        fill(1, 1, acc);
        wait_result(rc);
        check_frame("f5", acc, s0);
        chk("f5_index", res_index, 16'h8000);
        handshake();

        chk("ready_while_busy", rviol, 0);
        chk("m_outside_stream", leak, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
